// File: rtl/pixel_layer_mixer_if.sv
// Pixel-mixer port bundle: game-side layer/priority/palette inputs and DAC-side RGB outputs.
// The master modport belongs to the game logic and the slave modport to the mixer.
interface pixel_layer_mixer_if #(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = 6,
  parameter int COLOR_W    = 8
);
  localparam int RANK_W = $clog2(NUM_LAYERS);
  localparam int NPAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

  // Handshake: there is no ready. PixelEn is a qualifier, and the pixel on
  // LayerPix/Blank/BgIdx is consumed on every Clk edge where PixelEn=1. The sink
  // cannot stall, and the pipeline only moves on those edges. PrioWr, FrameStart
  // and PalWe are single-cycle commands that take effect on the edge where they are high.
  logic                           PixelEn;
  logic                           Blank;
  logic                           FrameStart;
  logic [NUM_LAYERS*IDX_W-1:0]    LayerPix;
  logic [IDX_W-1:0]               BgIdx;
  logic                           PrioWr;
  logic [NUM_LAYERS*RANK_W-1:0]   PrioData;
  logic                           PalWe;
  logic [IDX_W-1:0]               PalAddr;
  logic [3*COLOR_W-1:0]           PalData;
  logic [COLOR_W-1:0]             Red;
  logic [COLOR_W-1:0]             Green;
  logic [COLOR_W-1:0]             Blue;
  logic                           BlankOut;
  logic [NPAIRS-1:0]              CollideFrame;

  modport master (
    output PixelEn, Blank, FrameStart, LayerPix, BgIdx,
    output PrioWr, PrioData, PalWe, PalAddr, PalData,
    input  Red, Green, Blue, BlankOut, CollideFrame
  );

  modport slave (
    input  PixelEn, Blank, FrameStart, LayerPix, BgIdx,
    input  PrioWr, PrioData, PalWe, PalAddr, PalData,
    output Red, Green, Blue, BlankOut, CollideFrame
  );
endinterface

// File: rtl/pixel_layer_mixer.sv
// N-layer pixel compositor: priority resolve, then palette lookup, then RGB to the DAC (3 PixelEn strobes).
// Optional feature macro: MIXER_COLLIDE_EN enables per-frame layer-pair overlap flags.
module pixel_layer_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = 6,
  parameter int COLOR_W    = 8
) (
  input logic                Clk,
  input logic                Reset_n,
  pixel_layer_mixer_if.slave bus
);
  localparam int RANK_W = $clog2(NUM_LAYERS);
  localparam int PIX_W  = NUM_LAYERS * IDX_W;
  localparam int PRIO_W = NUM_LAYERS * RANK_W;
  localparam int RGB_W  = 3 * COLOR_W;

  function automatic logic [PRIO_W-1:0] prio_identity();
    logic [PRIO_W-1:0] v;
    v = '0;
    for (int r = 0; r < NUM_LAYERS; r++) v[r*RANK_W +: RANK_W] = RANK_W'(r);
    return v;
  endfunction

  localparam logic [PRIO_W-1:0] PRIO_RESET = prio_identity();

  logic [PIX_W-1:0]  s1_pix_q, s1_pix_d;
  logic              s1_blank_q, s1_blank_d;
  logic [IDX_W-1:0]  s1_bg_q, s1_bg_d;
  logic [IDX_W-1:0]  s2_idx_q, s2_idx_d;
  logic              s2_blank_q, s2_blank_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              blank_out_q, blank_out_d;
  logic [PRIO_W-1:0] prio_shadow_q, prio_shadow_d;
  logic [PRIO_W-1:0] prio_active_q, prio_active_d;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;

  // Palette RAM is deliberately left out of reset.
  logic [RGB_W-1:0]  pal_mem [2**IDX_W];

  always_ff @(posedge Clk) begin
    if (bus.PalWe) pal_mem[bus.PalAddr] <= bus.PalData;
  end

  // Lowest rank with an opaque layer wins. Ranks naming a nonexistent layer never match any k.
  always_comb begin
    win_idx   = s1_bg_q;
    win_found = 1'b0;
    for (int r = 0; r < NUM_LAYERS; r++) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (!win_found && (prio_active_q[r*RANK_W +: RANK_W] == RANK_W'(k)) &&
            (s1_pix_q[k*IDX_W +: IDX_W] != '0)) begin
          win_found = 1'b1;
          win_idx   = s1_pix_q[k*IDX_W +: IDX_W];
        end
      end
    end
  end

  always_comb begin
    s1_pix_d    = s1_pix_q;
    s1_blank_d  = s1_blank_q;
    s1_bg_d     = s1_bg_q;
    s2_idx_d    = s2_idx_q;
    s2_blank_d  = s2_blank_q;
    rgb_d       = rgb_q;
    blank_out_d = blank_out_q;
    if (bus.PixelEn) begin
      s1_pix_d    = bus.LayerPix;
      s1_blank_d  = bus.Blank;
      s1_bg_d     = bus.BgIdx;
      s2_idx_d    = win_idx;
      s2_blank_d  = s1_blank_q;
      // Combinational read sampled on the same edge as a write returns the old entry.
      rgb_d       = s2_blank_q ? pal_mem[s2_idx_q] : '0;
      blank_out_d = s2_blank_q;
    end
    prio_shadow_d = bus.PrioWr ? bus.PrioData : prio_shadow_q;
    prio_active_d = bus.FrameStart ? prio_shadow_d : prio_active_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_pix_q      <= '0;
      s1_blank_q    <= 1'b0;
      s1_bg_q       <= '0;
      s2_idx_q      <= '0;
      s2_blank_q    <= 1'b0;
      rgb_q         <= '0;
      blank_out_q   <= 1'b0;
      prio_shadow_q <= PRIO_RESET;
      prio_active_q <= PRIO_RESET;
    end else begin
      s1_pix_q      <= s1_pix_d;
      s1_blank_q    <= s1_blank_d;
      s1_bg_q       <= s1_bg_d;
      s2_idx_q      <= s2_idx_d;
      s2_blank_q    <= s2_blank_d;
      rgb_q         <= rgb_d;
      blank_out_q   <= blank_out_d;
      prio_shadow_q <= prio_shadow_d;
      prio_active_q <= prio_active_d;
    end
  end

  assign bus.Red      = rgb_q[2*COLOR_W +: COLOR_W];
  assign bus.Green    = rgb_q[COLOR_W +: COLOR_W];
  assign bus.Blue     = rgb_q[0 +: COLOR_W];
  assign bus.BlankOut = blank_out_q;

`ifdef MIXER_COLLIDE_EN
  localparam int NPAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

  logic [NPAIRS-1:0] hits;
  logic [NPAIRS-1:0] acc_q, acc_d;
  logic [NPAIRS-1:0] collide_q, collide_d;

  // Hits are taken from the visible pixel entering S1. Pair (i,j) maps to bit i*(2N-i-1)/2 + (j-i-1).
  always_comb begin
    hits = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      for (int j = i + 1; j < NUM_LAYERS; j++) begin
        if (bus.PixelEn && bus.Blank && (bus.LayerPix[i*IDX_W +: IDX_W] != '0) &&
            (bus.LayerPix[j*IDX_W +: IDX_W] != '0))
          hits[i*(2*NUM_LAYERS-i-1)/2 + j-i-1] = 1'b1;
      end
    end
    acc_d     = bus.FrameStart ? '0 : (acc_q | hits);
    collide_d = bus.FrameStart ? (acc_q | hits) : collide_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q     <= '0;
      collide_q <= '0;
    end else begin
      acc_q     <= acc_d;
      collide_q <= collide_d;
    end
  end

  assign bus.CollideFrame = collide_q;
`else
  assign bus.CollideFrame = '0;
`endif

endmodule

// File: tb/tb_pixel_layer_mixer.sv
// Directed plus random bench for pixel_layer_mixer. RGB/BlankOut expectations are queued per strobe.
// Collision expectations follow MIXER_COLLIDE_EN.
`timescale 1ns/1ps
module tb_pixel_layer_mixer;
  localparam int NL = 4;
  localparam int IW = 6;
  localparam int CW = 8;
  localparam int RW = 2;
  localparam int NP = 6;
  localparam int PW = NL * IW;
  localparam int OW = 3 * CW + 1;
  localparam logic [NL*RW-1:0] PRIO_ID = 8'b11_10_01_00;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #10 Clk = ~Clk;

  pixel_layer_mixer_if #(.NUM_LAYERS(NL), .IDX_W(IW), .COLOR_W(CW)) bus ();

  pixel_layer_mixer #(.NUM_LAYERS(NL), .IDX_W(IW), .COLOR_W(CW)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  logic [3*CW-1:0]  pal_m [2**IW];
  logic [NL*RW-1:0] prio_sh_m, prio_act_m;
  logic [OW-1:0]    exp_q [$];
  logic [OW-1:0]    last_exp;
  logic [NP-1:0]    collide_exp;
  logic [IW-1:0]    pool [5];
  int               n_vec, n_err;

  function automatic logic [PW-1:0] mk(input logic [IW-1:0] l0, input logic [IW-1:0] l1,
                                       input logic [IW-1:0] l2, input logic [IW-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Scan ranks from the bottom up so the highest-priority opaque layer is written last.
  function automatic logic [OW-1:0] model(input logic [PW-1:0] pix, input logic blank,
                                          input logic [IW-1:0] bg);
    logic [IW-1:0] idx;
    logic [RW-1:0] l;
    idx = bg;
    for (int r = NL - 1; r >= 0; r--) begin
      l = prio_act_m[r*RW +: RW];
      if (pix[l*IW +: IW] != '0) idx = pix[l*IW +: IW];
    end
    return blank ? {pal_m[idx], 1'b1} : '0;
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.Red, bus.Green, bus.Blue, bus.BlankOut};
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] o, input logic [OW-1:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic restart_scoreboard();
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    last_exp = '0;
  endtask

  task automatic strobe(input string tag, input logic [PW-1:0] pix, input logic blank,
                        input logic [IW-1:0] bg);
    bus.PixelEn  = 1'b1;
    bus.LayerPix = pix;
    bus.Blank    = blank;
    bus.BgIdx    = bg;
    if (bus.PalWe) pal_m[bus.PalAddr] = bus.PalData;
    exp_q.push_back(model(pix, blank, bg));
    @(posedge Clk);
    #1;
    bus.PixelEn = 1'b0;
    bus.PalWe   = 1'b0;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s observed=%h expected=queue-empty", tag, obs());
    end else begin
      last_exp = exp_q.pop_front();
      check(tag, obs(), last_exp);
    end
  endtask

  task automatic flush();
    strobe("flush", '0, 1'b0, '0);
    strobe("flush", '0, 1'b0, '0);
  endtask

  task automatic pal_write(input logic [IW-1:0] a, input logic [3*CW-1:0] d);
    bus.PalWe = 1'b1; bus.PalAddr = a; bus.PalData = d;
    pal_m[a] = d;
    @(posedge Clk);
    #1;
    bus.PalWe = 1'b0;
  endtask

  task automatic prio_write(input logic [NL*RW-1:0] d);
    bus.PrioWr = 1'b1; bus.PrioData = d;
    prio_sh_m = d;
    @(posedge Clk);
    #1;
    bus.PrioWr = 1'b0;
  endtask

  task automatic frame_start(input logic [NL*RW-1:0] d, input logic with_wr);
    bus.FrameStart = 1'b1;
    bus.PrioWr     = with_wr;
    bus.PrioData   = d;
    if (with_wr) prio_sh_m = d;
    prio_act_m = prio_sh_m;
    @(posedge Clk);
    #1;
    bus.FrameStart = 1'b0;
    bus.PrioWr     = 1'b0;
  endtask

  task automatic check_collide(input string tag, input logic [NP-1:0] e);
    check(tag, OW'(bus.CollideFrame), OW'(e));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    bus.PixelEn = 1'b0; bus.Blank = 1'b0; bus.FrameStart = 1'b0; bus.LayerPix = '0;
    bus.BgIdx = '0; bus.PrioWr = 1'b0; bus.PrioData = '0; bus.PalWe = 1'b0;
    bus.PalAddr = '0; bus.PalData = '0;
    prio_sh_m = PRIO_ID; prio_act_m = PRIO_ID;
    pool = '{6'd0, 6'd3, 6'd5, 6'd7, 6'd9};
    `ifdef MIXER_COLLIDE_EN
      collide_exp = 6'b010000;
    `else
      collide_exp = '0;
    `endif

    repeat (2) @(posedge Clk);
    #1;
    check("reset_rgb", obs(), '0);
    check_collide("reset_collide", '0);
    Reset_n = 1'b1;
    restart_scoreboard();

    pal_write(6'd0,  24'h010203);
    pal_write(6'd3,  24'h112233);
    pal_write(6'd5,  24'hFF8000);
    pal_write(6'd7,  24'h445566);
    pal_write(6'd9,  24'h778899);
    pal_write(6'd10, 24'hAABBCC);

    // Latency: the first two strobes still show reset contents.
    strobe("lat_s1", mk(0, 5, 0, 0), 1'b1, 6'd0);
    strobe("lat_s2", '0, 1'b0, 6'd0);
    strobe("lat_s3", '0, 1'b0, 6'd0);

    // Priority: a shadow write takes effect only at FrameStart.
    strobe("prio_ident", mk(3, 0, 7, 0), 1'b1, 6'd9);
    prio_write(8'b11_01_00_10);
    strobe("prio_shadow", mk(3, 0, 7, 0), 1'b1, 6'd9);
    flush();
    frame_start('0, 1'b0);
    strobe("prio_active", mk(3, 0, 7, 0), 1'b1, 6'd9);
    flush();
    frame_start(8'b10_10_10_10, 1'b1);
    strobe("prio_unlisted", mk(3, 5, 0, 0), 1'b1, 6'd9);
    strobe("prio_dup", mk(3, 0, 7, 0), 1'b1, 6'd9);
    flush();
    frame_start(PRIO_ID, 1'b1);

    // Transparency, blanking, and BgIdx=0 reaching entry 0.
    strobe("bg_vis", '0, 1'b1, 6'd9);
    strobe("bg_blank", '0, 1'b0, 6'd9);
    strobe("bg_zero", '0, 1'b1, 6'd0);
    flush();

    // Read and write of the same palette address on one edge returns the old entry.
    strobe("rdw_a", mk(10, 0, 0, 0), 1'b1, 6'd0);
    strobe("rdw_b", '0, 1'b0, 6'd0);
    bus.PalWe = 1'b1; bus.PalAddr = 6'd10; bus.PalData = 24'hDDEEFF;
    strobe("rdw_old", mk(10, 0, 0, 0), 1'b1, 6'd0);
    flush();

    // Random pixels with a 10-cycle stall in the middle.
    for (int i = 0; i < 24; i++) begin
      if (i == 12) begin
        for (int c = 0; c < 10; c++) begin
          @(posedge Clk);
          #1;
          check("stall_hold", obs(), last_exp);
        end
      end
      strobe("rand", mk(pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
                        pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)]),
             1'($urandom_range(0, 1)), pool[$urandom_range(0, 4)]);
    end
    flush();
    frame_start('0, 1'b0);

    // Collision: layers 1 and 3 overlap on one visible pixel, plus one blanked overlap.
    strobe("col_a", mk(0, 5, 0, 3), 1'b1, 6'd0);
    strobe("col_b", mk(3, 3, 0, 0), 1'b0, 6'd0);
    strobe("col_c", mk(3, 0, 0, 0), 1'b1, 6'd0);
    flush();
    frame_start('0, 1'b0);
    check_collide("collide_set", collide_exp);
    strobe("col_d", mk(3, 0, 0, 0), 1'b1, 6'd0);
    strobe("col_e", mk(0, 0, 7, 0), 1'b1, 6'd0);
    flush();
    frame_start('0, 1'b0);
    check_collide("collide_clear", '0);
    strobe("col_f", mk(0, 5, 0, 3), 1'b1, 6'd0);
    flush();
    frame_start('0, 1'b0);
    check_collide("collide_again", collide_exp);

    // Mid-frame asynchronous reset, then resume.
    strobe("pre_rst_a", mk(0, 5, 0, 0), 1'b1, 6'd0);
    strobe("pre_rst_b", mk(0, 5, 0, 0), 1'b1, 6'd0);
    strobe("pre_rst_c", mk(0, 5, 0, 0), 1'b1, 6'd0);
    #4;
    Reset_n = 1'b0;
    #1;
    check("async_rst_rgb", obs(), '0);
    check_collide("async_rst_collide", '0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    prio_sh_m = PRIO_ID; prio_act_m = PRIO_ID;
    restart_scoreboard();
    strobe("resume_1", mk(0, 0, 0, 7), 1'b1, 6'd0);
    strobe("resume_2", '0, 1'b1, 6'd9);
    strobe("resume_3", '0, 1'b0, 6'd0);
    strobe("resume_4", '0, 1'b0, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
